sg_stream_filter: RTL and testbench

SG_STREAM_FILTER -- requirements
Module: sg_stream_filter

---
 rtl/sg_stream_filter.sv | 212 +++++++++++++++++++++
 tb/tb_sg_stream_filter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sg_stream_filter.sv
// sg_stream_filter: framed Savitzky-Golay FIR, edge samples replicated at frame ends.
// Define SG_COEF_LOAD_EN to add a coefficient write port; writes are honoured in IDLE only.
module sg_stream_filter #(
  parameter int DATA_W  = 8,
  parameter int WINDOW  = 7,
  parameter int COEF_W  = 16,
  parameter int FRAC_W  = 12,
  parameter int FRAME_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
`ifdef SG_COEF_LOAD_EN
  ,
  input  logic                      coef_we,
  input  logic [$clog2(WINDOW)-1:0] coef_addr,
  input  logic [COEF_W-1:0]         coef_data
`endif
);

  // state | meaning
  // IDLE  | waiting for the first sample of a frame
  // RUN   | accepting samples into the window
  // MAC   | one tap per cycle, then round and saturate
  // OUT   | result held until downstream accepts it
  // FLUSH | replicating the final sample past the frame end
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_MAC   = 3'd2;
  localparam logic [2:0] S_OUT   = 3'd3;
  localparam logic [2:0] S_FLUSH = 3'd4;

  localparam int H     = (WINDOW - 1) / 2;
  localparam int TW    = $clog2(WINDOW);
  localparam int ACC_W = DATA_W + COEF_W + $clog2(WINDOW);

  localparam logic [TW-1:0]          H_CNT    = TW'(H);
  localparam logic [TW-1:0]          MAC_DONE = TW'(WINDOW);
  localparam logic signed [ACC_W-1:0] RND    = ACC_W'(1 << (FRAC_W - 1));
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-(1 << (DATA_W - 1)));

  if (WINDOW < 3 || (WINDOW % 2) == 0) begin : g_bad_window
    $error("sg_stream_filter: WINDOW must be odd and at least 3");
  end

`ifndef SG_COEF_LOAD_EN
  if (WINDOW != 7 || FRAC_W != 12) begin : g_bad_fixed_cfg
    $error("sg_stream_filter: fixed coefficients need WINDOW=7 and FRAC_W=12");
  end
`endif

  // Quadratic smoothing for 7 taps; other window sizes start as a pass-through.
  function automatic logic [COEF_W-1:0] def_coef(input int i);
    int v;
    if (WINDOW == 7) begin
      case (i)
        0, 6:    v = -390;
        1, 5:    v = 585;
        2, 4:    v = 1170;
        default: v = 1365;
      endcase
    end else begin
      v = (i == H) ? (1 << FRAC_W) : 0;
    end
    return COEF_W'(v);
  endfunction

  logic [2:0]                state;
  logic signed [DATA_W-1:0]  win [WINDOW];
  logic [COEF_W-1:0]         coef [WINDOW];
  logic signed [ACC_W-1:0]   acc;
  logic [TW-1:0]             mac_cnt;
  logic [TW-1:0]             shift_cnt;
  logic [TW-1:0]             shift_nxt;
  logic                      reach_h;
  logic [FRAME_W-1:0]        in_cnt;
  logic [FRAME_W-1:0]        out_cnt;
  logic [FRAME_W-1:0]        out_cnt_nxt;
  logic                      last_seen;
  logic                      win_load;
  logic                      win_shift;
  logic signed [DATA_W-1:0]  shift_val;
  logic signed [ACC_W-1:0]   tap_c;
  logic signed [ACC_W-1:0]   tap_x;
  logic signed [ACC_W-1:0]   prod;
  logic signed [ACC_W-1:0]   rnd_sum;
  logic signed [ACC_W-1:0]   rnd_shift;
  logic [DATA_W-1:0]         sat_val;

  assign in_ready    = !rst && (state == S_IDLE || state == S_RUN);
  assign out_valid   = (state == S_OUT);
  assign out_cnt_nxt = out_cnt + 1'b1;

`ifdef SG_COEF_LOAD_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WINDOW; i++) coef[i] <= def_coef(i);
    end else if (coef_we && state == S_IDLE && int'(coef_addr) < WINDOW) begin
      coef[coef_addr] <= coef_data;
    end
  end
`else
  for (genvar gi = 0; gi < WINDOW; gi++) begin : g_coef
    assign coef[gi] = def_coef(gi);
  end
`endif

  always_comb begin
    shift_nxt = (shift_cnt >= H_CNT) ? H_CNT : shift_cnt + 1'b1;
    reach_h   = (shift_nxt == H_CNT);
    win_load  = (state == S_IDLE) && in_valid;
    win_shift = ((state == S_RUN) && in_valid) || (state == S_FLUSH);
    shift_val = (state == S_FLUSH) ? win[WINDOW-1] : in_data;
  end

  always_comb begin
    tap_c     = ACC_W'($signed(coef[mac_cnt]));
    tap_x     = ACC_W'(win[mac_cnt]);
    prod      = tap_c * tap_x;
    rnd_sum   = acc + RND;
    rnd_shift = rnd_sum >>> FRAC_W;
    if (rnd_shift > SAT_HI)      sat_val = SAT_HI[DATA_W-1:0];
    else if (rnd_shift < SAT_LO) sat_val = SAT_LO[DATA_W-1:0];
    else                         sat_val = rnd_shift[DATA_W-1:0];
  end

  // win[0] is the oldest sample, win[WINDOW-1] the newest.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WINDOW; i++) win[i] <= '0;
    end else if (win_load) begin
      for (int i = 0; i < WINDOW; i++) win[i] <= in_data;
    end else if (win_shift) begin
      for (int i = 0; i < WINDOW - 1; i++) win[i] <= win[i+1];
      win[WINDOW-1] <= shift_val;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      acc       <= '0;
      mac_cnt   <= '0;
      shift_cnt <= '0;
      in_cnt    <= '0;
      out_cnt   <= '0;
      last_seen <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            shift_cnt <= '0;
            in_cnt    <= FRAME_W'(1);
            out_cnt   <= '0;
            last_seen <= in_last;
            state     <= in_last ? S_FLUSH : S_RUN;
          end
        end
        S_RUN: begin
          if (in_valid) begin
            in_cnt    <= in_cnt + 1'b1;
            last_seen <= in_last;
            shift_cnt <= shift_nxt;
            if (reach_h)      state <= S_MAC;
            else if (in_last) state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          shift_cnt <= shift_nxt;
          if (reach_h) state <= S_MAC;
        end
        S_MAC: begin
          if (mac_cnt == MAC_DONE) begin
            out_data <= sat_val;
            out_last <= last_seen && (out_cnt_nxt == in_cnt);
            acc      <= '0;
            mac_cnt  <= '0;
            state    <= S_OUT;
          end else begin
            acc     <= acc + prod;
            mac_cnt <= mac_cnt + 1'b1;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            out_cnt <= out_cnt_nxt;
            if (out_cnt_nxt == in_cnt) begin
              last_seen <= 1'b0;
              state     <= S_IDLE;
            end else if (last_seen) begin
              state <= S_FLUSH;
            end else begin
              state <= S_RUN;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sg_stream_filter.sv
// tb_sg_stream_filter: table vectors, hand-written corner sequences and random frames
// checked against a direct evaluation of the clamped-window filter equation.
module tb_sg_stream_filter;
  localparam int DATA_W  = 8;
  localparam int WINDOW  = 7;
  localparam int COEF_W  = 16;
  localparam int FRAC_W  = 12;
  localparam int FRAME_W = 16;
  localparam int H       = (WINDOW - 1) / 2;

  typedef struct packed {
    logic [7:0]         frame;
    logic signed [15:0] x;
    logic signed [15:0] y;
    logic               last;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_last = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
`ifdef SG_COEF_LOAD_EN
  logic                      coef_we = 1'b0;
  logic [$clog2(WINDOW)-1:0] coef_addr = '0;
  logic [COEF_W-1:0]         coef_data = '0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cf[WINDOW];
  int rx_d[$];
  bit rx_l[$];
  bit stall    = 1'b0;
  bit rdy_rand = 1'b0;

  always #5 clk = ~clk;

  sg_stream_filter #(
    .DATA_W(DATA_W), .WINDOW(WINDOW), .COEF_W(COEF_W), .FRAC_W(FRAC_W), .FRAME_W(FRAME_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
`ifdef SG_COEF_LOAD_EN
    , .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data)
`endif
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out", name);
  endtask

  // y[n] = sat(round(sum_k c[k] * x[clamp(n+k-H)])) evaluated directly.
  function automatic int model_y(input int xs[$], input int n);
    longint acc = 0;
    longint r;
    int idx;
    for (int k = 0; k < WINDOW; k++) begin
      idx = n + k - H;
      if (idx < 0) idx = 0;
      if (idx > xs.size() - 1) idx = xs.size() - 1;
      acc += longint'(cf[k]) * longint'(xs[idx]);
    end
    r = (acc + longint'(2 ** (FRAC_W - 1))) >>> FRAC_W;
    if (r > longint'(2 ** (DATA_W - 1) - 1)) r = longint'(2 ** (DATA_W - 1) - 1);
    if (r < -longint'(2 ** (DATA_W - 1))) r = -longint'(2 ** (DATA_W - 1));
    return int'(r);
  endfunction

  task automatic model_frame(input int xs[$], output int ed[$], output bit el[$]);
    ed.delete();
    el.delete();
    for (int n = 0; n < xs.size(); n++) begin
      ed.push_back(model_y(xs, n));
      el.push_back(n == xs.size() - 1);
    end
  endtask

  task automatic drive(input int xs[$], input bit mark_last, input int gap_pct);
    int n;
    foreach (xs[i]) begin
      while (int'($urandom_range(99)) < gap_pct) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = DATA_W'(xs[i]);
      in_last  = mark_last && (i == xs.size() - 1);
      n = 0;
      while (!in_ready && n < 300) begin
        @(negedge clk);
        n++;
      end
      if (n >= 300) begin
        timeout("in_ready wait");
        break;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic expect_outputs(input string tag, input int ed[$], input bit el[$]);
    int n = 0;
    while (rx_d.size() < ed.size() && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (30) @(negedge clk);
    check({tag, " count"}, rx_d.size(), ed.size());
    foreach (ed[i]) begin
      if (i < rx_d.size()) begin
        check($sformatf("%s data[%0d]", tag, i), rx_d[i], ed[i]);
        check($sformatf("%s last[%0d]", tag, i), int'(rx_l[i]), int'(el[i]));
      end
    end
    rx_d.delete();
    rx_l.delete();
  endtask

  function automatic vec_t mk(input int f, input int x, input int y, input bit l);
    vec_t v;
    v.frame = 8'(f);
    v.x     = 16'(x);
    v.y     = 16'(y);
    v.last  = l;
    return v;
  endfunction

  // Output side: drives out_ready, collects transfers, checks held outputs stay put.
  initial begin
    bit held = 1'b0;
    int held_d = 0;
    int held_l = 0;
    forever begin
      @(negedge clk);
      out_ready = stall ? 1'b0 : (rdy_rand ? (int'($urandom_range(99)) < 60) : 1'b1);
      if (!rst && held) begin
        check("held out_valid", int'(out_valid), 1);
        check("held out_data", int'($signed(out_data)), held_d);
        check("held out_last", int'(out_last), held_l);
        check("held in_ready", int'(in_ready), 0);
      end
      held   = !rst && out_valid && !out_ready;
      held_d = int'($signed(out_data));
      held_l = int'(out_last);
      if (!rst && out_valid && out_ready) begin
        rx_d.push_back(int'($signed(out_data)));
        rx_l.push_back(out_last);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[$];
    int xs[$];
    int ed[$];
    bit el[$];
    int cnt;
    int d0;

    cf = '{-390, 585, 1170, 1365, 1170, 585, -390};

    for (int i = 0; i < 10; i++) vt.push_back(mk(0, 10, 10, i == 9));
    vt.push_back(mk(1, 0, -10, 0));  vt.push_back(mk(1, 0, 14, 0));
    vt.push_back(mk(1, 0, 29, 0));   vt.push_back(mk(1, 100, 33, 0));
    vt.push_back(mk(1, 0, 29, 0));   vt.push_back(mk(1, 0, 14, 0));
    vt.push_back(mk(1, 0, -10, 1));
    vt.push_back(mk(2, 50, 50, 1));
    vt.push_back(mk(3, 100, 67, 0)); vt.push_back(mk(3, 0, 33, 0));
    vt.push_back(mk(3, 0, 5, 0));    vt.push_back(mk(3, 0, -10, 0));
    vt.push_back(mk(3, 0, 0, 1));
    for (int i = 0; i < 3; i++) vt.push_back(mk(4, -128, -128, i == 2));
    vt.push_back(mk(5, 0, 33, 0));   vt.push_back(mk(5, 100, 67, 1));

    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset in_ready", int'(in_ready), 0);
    check("reset out_valid", int'(out_valid), 0);
    check("reset out_data", int'(out_data), 0);
    check("reset out_last", int'(out_last), 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle in_ready", int'(in_ready), 1);

    xs.delete(); ed.delete(); el.delete();
    foreach (vt[i]) begin
      xs.push_back(int'(vt[i].x));
      ed.push_back(int'(vt[i].y));
      el.push_back(vt[i].last);
      if (vt[i].last) begin
        drive(xs, 1'b1, 0);
        expect_outputs($sformatf("vec f%0d", vt[i].frame), ed, el);
        xs.delete(); ed.delete(); el.delete();
      end
    end

    // Latency: 4-sample frame back to back, first result WINDOW+1 edges after 4th accept.
    xs = '{0, 1, 2, 3};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("lat in_ready[%0d]", i), int'(in_ready), 1);
      in_valid = 1'b1;
      in_data  = DATA_W'(xs[i]);
      in_last  = (i == 3);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("lat in_ready in MAC", int'(in_ready), 0);
    cnt = 0;
    while (!out_valid && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    check("lat edges to out_valid", cnt, WINDOW + 1);
    model_frame(xs, ed, el);
    expect_outputs("lat", ed, el);

    // Back-pressure: hold out_ready low 5 cycles with a result pending.
    xs.delete();
    for (int i = 0; i < 7; i++) xs.push_back(int'($urandom_range(255)) - 128);
    stall = 1'b1;
    fork
      drive(xs, 1'b1, 0);
      begin
        cnt = 0;
        while (!out_valid && cnt < 300) begin
          @(negedge clk);
          cnt++;
        end
        if (cnt >= 300) timeout("stall out_valid wait");
        d0 = int'($signed(out_data));
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          check($sformatf("stall data[%0d]", i), int'($signed(out_data)), d0);
          check($sformatf("stall in_ready[%0d]", i), int'(in_ready), 0);
        end
        stall = 1'b0;
      end
    join
    model_frame(xs, ed, el);
    expect_outputs("stall", ed, el);

    // Reset mid-frame: partial frame discarded, next frame clean.
    xs = '{5, 6, 7};
    drive(xs, 1'b0, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst in_ready", int'(in_ready), 0);
    check("midrst out_valid", int'(out_valid), 0);
    rst = 1'b0;
    rx_d.delete();
    rx_l.delete();
    xs.delete();
    for (int i = 0; i < 7; i++) xs.push_back(20);
    drive(xs, 1'b1, 0);
    ed.delete(); el.delete();
    for (int i = 0; i < 7; i++) begin
      ed.push_back(20);
      el.push_back(i == 6);
    end
    expect_outputs("midrst", ed, el);

    // Random frames with input gaps and random downstream readiness.
    rdy_rand = 1'b1;
    for (int f = 0; f < 12; f++) begin
      xs.delete();
      cnt = int'($urandom_range(20, 1));
      for (int i = 0; i < cnt; i++) xs.push_back(int'($urandom_range(255)) - 128);
      drive(xs, 1'b1, 30);
      model_frame(xs, ed, el);
      expect_outputs($sformatf("rand f%0d", f), ed, el);
    end
    rdy_rand = 1'b0;

`ifdef SG_COEF_LOAD_EN
    for (int i = 0; i <= WINDOW; i++) begin
      @(negedge clk);
      coef_we   = 1'b1;
      coef_addr = 3'(i);
      coef_data = (i < WINDOW) ? COEF_W'(4096) : COEF_W'(0);
    end
    @(negedge clk);
    coef_we = 1'b0;
    for (int i = 0; i < WINDOW; i++) cf[i] = 4096;
    xs.delete();
    for (int i = 0; i < 5; i++) xs.push_back(100);
    drive(xs, 1'b1, 0);
    model_frame(xs, ed, el);
    expect_outputs("coef sat", ed, el);

    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cf = '{-390, 585, 1170, 1365, 1170, 585, -390};
    xs = '{10, 10, 10};
    drive(xs, 1'b1, 0);
    model_frame(xs, ed, el);
    expect_outputs("coef restore", ed, el);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
